req_arbiter8: RTL and testbench

Registered 8-way request arbiter sitting directly upstream of the 8-to-3 encoder. It latches request pulses from up to eight sources into a sticky pending vector and selects one request at a time. It presents the winner as a strictly one-hot grant vector, which the downstream encoder converts to a 3-bit index. Grants are issued under a valid/ready handshake, at up to one grant per clock.

---
 rtl/req_arbiter8.sv | 124 ++++++++++++
 tb/tb_req_arbiter8.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter8.sv
// Registered 8-way request arbiter: sticky pending capture, round-robin or
// fixed-priority selection, one-hot grant under a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant presented; waits for any pending request
// S_GRANT | gnt/valid presented; holds until accepted, then chains or idles

module req_arbiter8 #(
   parameter bit RR = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       ready,
   output logic [7:0] gnt,
   output logic       valid,
   output logic [7:0] pending
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_pend;
   logic [7:0] w_pend_nxt;
   logic [2:0] r_ptr;
   logic [2:0] w_ptr_nxt;
   logic [7:0] r_gnt;
   logic [7:0] w_gnt_nxt;
   logic       r_valid;
   logic       w_valid_nxt;
   logic       w_acc;
   logic [2:0] w_k_next;
   logic [7:0] w_rem;

   // Descending loops let the last match (lowest offset / highest index) win.
   function automatic logic [7:0] f_select(input logic [7:0] v, input logic [2:0] p);
      logic [7:0] res;
      logic [2:0] idx;
      res = 8'h00;
      if (RR) begin
         for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (v[idx]) res = 8'd1 << idx;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (v[i]) res = 8'd1 << i;
         end
      end
      return res;
   endfunction

   function automatic logic [2:0] f_index(input logic [7:0] v);
      logic [2:0] k;
      k = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) k = 3'(i);
      end
      return k;
   endfunction

   assign w_acc      = r_valid & ready;
   assign w_k_next   = f_index(r_gnt) + 3'd1;
   assign w_rem      = r_pend & ~r_gnt;
   assign w_pend_nxt = (r_pend & ~(w_acc ? r_gnt : 8'h00)) | req;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_valid_nxt = r_valid;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (r_pend != 8'h00) begin
               w_gnt_nxt   = f_select(r_pend, r_ptr);
               w_valid_nxt = 1'b1;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            // Selection uses the registered remainder only, so a request
            // captured on this edge waits at least one more cycle.
            if (w_acc) begin
               w_ptr_nxt = w_k_next;
               if (w_rem != 8'h00) begin
                  w_gnt_nxt = f_select(w_rem, w_k_next);
               end else begin
                  w_gnt_nxt   = 8'h00;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_gnt_nxt   = 8'h00;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pend  <= 8'h00;
         r_ptr   <= 3'd0;
         r_gnt   <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign valid   = r_valid;
   assign pending = r_pend;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: a round-robin and a fixed-priority
// instance, directed pulses, expected grants queued and checked on accept.

module tb_req_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_rr = 8'h00;
   logic [7:0] req_fp = 8'h00;
   logic       ready_rr = 1'b0;
   logic       ready_fp = 1'b0;
   logic [7:0] gnt_rr, gnt_fp, pend_rr, pend_fp;
   logic       valid_rr, valid_fp;

   logic [7:0] q_rr[$];
   logic [7:0] q_fp[$];
   logic [7:0] e_rr, e_fp;
   int         checks = 0;
   int         failures = 0;

   req_arbiter8 #(.RR(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req_rr), .ready(ready_rr),
      .gnt(gnt_rr), .valid(valid_rr), .pending(pend_rr)
   );

   req_arbiter8 #(.RR(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(req_fp), .ready(ready_fp),
      .gnt(gnt_fp), .valid(valid_fp), .pending(pend_fp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change at negedge+1; outputs and inputs are both stable here,
   // and a valid&ready seen now is accepted on the coming rising edge.
   always @(negedge clk) begin
      #3;
      if (valid_rr) chk("rr_onehot", {7'd0, $onehot(gnt_rr)}, 8'd1);
      if (valid_rr && ready_rr) begin
         if (q_rr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rr_unexpected_grant actual=%h expected=none", gnt_rr);
         end else begin
            e_rr = q_rr.pop_front();
            chk("rr_grant", gnt_rr, e_rr);
         end
      end
   end

   always @(negedge clk) begin
      #3;
      if (valid_fp) chk("fp_onehot", {7'd0, $onehot(gnt_fp)}, 8'd1);
      if (valid_fp && ready_fp) begin
         if (q_fp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fp_unexpected_grant actual=%h expected=none", gnt_fp);
         end else begin
            e_fp = q_fp.pop_front();
            chk("fp_grant", gnt_fp, e_fp);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      repeat (2) step();
      chk("rst_gnt_rr", gnt_rr, 8'h00);
      chk("rst_valid_rr", {7'd0, valid_rr}, 8'h00);
      chk("rst_pend_rr", pend_rr, 8'h00);
      chk("rst_gnt_fp", gnt_fp, 8'h00);
      chk("rst_valid_fp", {7'd0, valid_fp}, 8'h00);
      rst_n = 1'b1;
      step();

      // Round-robin sweep from ptr=0
      req_rr = 8'hFF; ready_rr = 1'b1;
      q_rr.push_back(8'h01); q_rr.push_back(8'h02); q_rr.push_back(8'h04); q_rr.push_back(8'h08);
      q_rr.push_back(8'h10); q_rr.push_back(8'h20); q_rr.push_back(8'h40); q_rr.push_back(8'h80);
      step(); req_rr = 8'h00;
      step();
      chk("sweep_pend", pend_rr, 8'hFF);
      chk("sweep_first_gnt", gnt_rr, 8'h01);
      repeat (8) step();
      chk("sweep_idle_valid", {7'd0, valid_rr}, 8'h00);
      chk("sweep_idle_pend", pend_rr, 8'h00);

      // ptr wrapped to 0: 8'h81 serves bit 0 before bit 7
      req_rr = 8'h81;
      q_rr.push_back(8'h01); q_rr.push_back(8'h80);
      step(); req_rr = 8'h00;
      repeat (3) step();
      chk("wrap_idle_valid", {7'd0, valid_rr}, 8'h00);

      // Single pulse
      req_rr = 8'h20;
      q_rr.push_back(8'h20);
      step(); req_rr = 8'h00;
      step();
      chk("pulse_valid", {7'd0, valid_rr}, 8'h01);
      chk("pulse_gnt", gnt_rr, 8'h20);
      step();
      chk("pulse_done_valid", {7'd0, valid_rr}, 8'h00);
      chk("pulse_done_pend", pend_rr, 8'h00);

      // Backpressure (ptr=6)
      ready_rr = 1'b0; req_rr = 8'h02;
      q_rr.push_back(8'h02); q_rr.push_back(8'h40);
      step(); req_rr = 8'h00;
      step();
      chk("bp_gnt0", gnt_rr, 8'h02);
      req_rr = 8'h40;
      step(); req_rr = 8'h00;
      chk("bp_gnt1", gnt_rr, 8'h02);
      step();
      chk("bp_gnt2", gnt_rr, 8'h02);
      chk("bp_valid", {7'd0, valid_rr}, 8'h01);
      chk("bp_pend", pend_rr, 8'h42);
      ready_rr = 1'b1;
      step();
      chk("bp_next_gnt", gnt_rr, 8'h40);
      step();
      chk("bp_idle", {7'd0, valid_rr}, 8'h00);

      // Re-arm on accept (ptr=7): order 04, 10, 04
      req_rr = 8'h14;
      q_rr.push_back(8'h04); q_rr.push_back(8'h10); q_rr.push_back(8'h04);
      step(); req_rr = 8'h00;
      step();
      chk("rearm_gnt0", gnt_rr, 8'h04);
      req_rr = 8'h04;
      step(); req_rr = 8'h00;
      chk("rearm_pend", pend_rr, 8'h14);
      chk("rearm_gnt1", gnt_rr, 8'h10);
      step();
      chk("rearm_gnt2", gnt_rr, 8'h04);
      step();
      chk("rearm_idle", {7'd0, valid_rr}, 8'h00);
      chk("rearm_pend_clear", pend_rr, 8'h00);

      // Fixed priority
      req_fp = 8'h81; ready_fp = 1'b1;
      q_fp.push_back(8'h80); q_fp.push_back(8'h01);
      step(); req_fp = 8'h00;
      repeat (3) step();
      chk("fp_idle0", {7'd0, valid_fp}, 8'h00);
      req_fp = 8'h04;
      q_fp.push_back(8'h04);
      step(); req_fp = 8'h00;
      repeat (2) step();
      chk("fp_idle1", {7'd0, valid_fp}, 8'h00);
      req_fp = 8'h81;
      q_fp.push_back(8'h80); q_fp.push_back(8'h01);
      step(); req_fp = 8'h00;
      step();
      chk("fp_ptr_gnt0", gnt_fp, 8'h80);
      step();
      chk("fp_ptr_gnt1", gnt_fp, 8'h01);
      step();
      chk("fp_idle2", {7'd0, valid_fp}, 8'h00);

      // Async reset while a grant is held
      ready_rr = 1'b0; req_rr = 8'h08;
      step(); req_rr = 8'h00;
      step();
      chk("ar_gnt_before", gnt_rr, 8'h08);
      #1;
      rst_n = 1'b0; ready_rr = 1'b1;
      #1;
      chk("ar_gnt", gnt_rr, 8'h00);
      chk("ar_valid", {7'd0, valid_rr}, 8'h00);
      chk("ar_pend", pend_rr, 8'h00);
      step(); req_rr = 8'h08;
      step(); rst_n = 1'b1; req_rr = 8'h00;
      repeat (2) step();
      chk("ar_post_valid", {7'd0, valid_rr}, 8'h00);
      chk("ar_post_pend", pend_rr, 8'h00);
      req_rr = 8'h01;
      q_rr.push_back(8'h01);
      step(); req_rr = 8'h00;
      step();
      chk("ar_fresh_gnt", gnt_rr, 8'h01);
      step();
      chk("ar_fresh_idle", {7'd0, valid_rr}, 8'h00);

      repeat (2) step();
      chk("rr_queue_left", 8'(q_rr.size()), 8'h00);
      chk("fp_queue_left", 8'(q_fp.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
